// File: rtl/riscv_imm_pkg.sv
// Shared definitions for the immediate generator.
//   imm_type_t   : immediate class reported alongside every decoded word
//   TYPE_*       : 7-bit base opcodes recognised by the decoder
//   F3_*         : funct3 values that turn an I-type ALU op into a shift
//   is_shift_f3  : true when an I-type ALU funct3 selects a shift
package riscv_imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_SHAMT = 3'd2,
        IMM_S     = 3'd3,
        IMM_B     = 3'd4,
        IMM_U     = 3'd5,
        IMM_J     = 3'd6
    } imm_type_t;

    localparam logic [6:0] TYPE_R       = 7'b0110011;
    localparam logic [6:0] TYPE_I_LOAD  = 7'b0000011;
    localparam logic [6:0] TYPE_I_JALR  = 7'b1100111;
    localparam logic [6:0] TYPE_I_ALU   = 7'b0010011;
    localparam logic [6:0] TYPE_S       = 7'b0100011;
    localparam logic [6:0] TYPE_SB      = 7'b1100011;
    localparam logic [6:0] TYPE_U_LUI   = 7'b0110111;
    localparam logic [6:0] TYPE_U_AUIPC = 7'b0010111;
    localparam logic [6:0] TYPE_UJ      = 7'b1101111;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for one instruction word.
// Ports:
//   inst     in   32    instruction word
//   imm      out  XLEN  sign/zero-extended immediate (0 for R and illegal)
//   imm_type out  3     immediate class
//   illegal  out  1     opcode not recognised
module imm_extract
    import riscv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_t       imm_type,
    output logic            illegal
);

    // Raw immediate fields as signed values; a size cast to XLEN then
    // sign-extends them.
    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [31:0] u_imm;
    logic signed [20:0] j_imm;
    logic        [5:0]  shamt;

    assign i_imm = inst[31:20];
    assign s_imm = {inst[31:25], inst[11:7]};
    assign b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign j_imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Shift amount is 5 bits on RV32 and 6 on RV64; funct7/funct6 above it
    // (e.g. the SRAI selector bit) never leaks into the immediate.
    assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};

    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (inst[6:0])
            TYPE_R: begin
                imm_type = IMM_NONE;
            end
            TYPE_I_LOAD, TYPE_I_JALR: begin
                imm_type = IMM_I;
                imm      = XLEN'(i_imm);
            end
            TYPE_I_ALU: begin
                if (is_shift_f3(inst[14:12])) begin
                    imm_type = IMM_SHAMT;
                    imm      = XLEN'(shamt);
                end else begin
                    imm_type = IMM_I;
                    imm      = XLEN'(i_imm);
                end
            end
            TYPE_S: begin
                imm_type = IMM_S;
                imm      = XLEN'(s_imm);
            end
            TYPE_SB: begin
                imm_type = IMM_B;
                imm      = XLEN'(b_imm);
            end
            TYPE_U_LUI, TYPE_U_AUIPC: begin
                imm_type = IMM_U;
                imm      = XLEN'(u_imm);
            end
            TYPE_UJ: begin
                imm_type = IMM_J;
                imm      = XLEN'(j_imm);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/immgen_pipe.sv
// Pipelined immediate generator with valid/ready handshake.
// Decodes the immediate of an instruction and computes pc + imm.
// Latency from input accept to out_valid is STAGES cycles (1 or 2).
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake for inst/pc
//   inst, pc             instruction word and its address
//   out_valid/out_ready  output handshake
//   imm_out, imm_type    extended immediate and its class
//   target               pc + imm_out modulo 2^XLEN
//   illegal              opcode not recognised
module immgen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_out,
    output imm_type_t       imm_type,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    logic [XLEN-1:0] ex_imm;
    imm_type_t       ex_type;
    logic            ex_ill;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst     (inst),
        .imm      (ex_imm),
        .imm_type (ex_type),
        .illegal  (ex_ill)
    );

    // Per-stage valid bits; vld_pipe[STAGES] is the output stage.
    logic [STAGES:1] vld_pipe;
    logic            tail_load;  // output stage may take new contents
    logic            head_load;  // stage 1 may take new contents

    // Combinational ready chain: a full stage still loads when its
    // contents leave on the same edge, so a stream never bubbles.
    assign tail_load = !vld_pipe[STAGES] || out_ready;

    generate
        if (STAGES == 1) begin : g_head1
            assign head_load = tail_load;
        end else begin : g_head2
            assign head_load = !vld_pipe[1] || tail_load;
        end
    endgenerate

    assign in_ready  = head_load;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else begin
            if (head_load) vld_pipe[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) begin
                if (tail_load) vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    end

    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] tgt_q;
    imm_type_t       type_q;
    logic            ill_q;

    generate
        if (STAGES == 1) begin : g_one
            // Extract and add in the same cycle, register once.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    imm_q  <= '0;
                    tgt_q  <= '0;
                    type_q <= IMM_NONE;
                    ill_q  <= 1'b0;
                end else if (in_valid && head_load) begin
                    imm_q  <= ex_imm;
                    tgt_q  <= pc + ex_imm;
                    type_q <= ex_type;
                    ill_q  <= ex_ill;
                end
            end
        end else begin : g_two
            // Stage 1 holds the decoded fields and pc; the adder sits
            // between stage 1 and the output stage.
            logic [XLEN-1:0] s1_imm;
            logic [XLEN-1:0] s1_pc;
            imm_type_t       s1_type;
            logic            s1_ill;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s1_imm  <= '0;
                    s1_pc   <= '0;
                    s1_type <= IMM_NONE;
                    s1_ill  <= 1'b0;
                end else if (in_valid && head_load) begin
                    s1_imm  <= ex_imm;
                    s1_pc   <= pc;
                    s1_type <= ex_type;
                    s1_ill  <= ex_ill;
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    imm_q  <= '0;
                    tgt_q  <= '0;
                    type_q <= IMM_NONE;
                    ill_q  <= 1'b0;
                end else if (vld_pipe[1] && tail_load) begin
                    imm_q  <= s1_imm;
                    tgt_q  <= s1_pc + s1_imm;
                    type_q <= s1_type;
                    ill_q  <= s1_ill;
                end
            end
        end
    endgenerate

    // Output registers only load on a handshake, so data holds while
    // out_valid && !out_ready.
    assign imm_out  = imm_q;
    assign target   = tgt_q;
    assign imm_type = type_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_immgen_pipe.sv
module tb_immgen_pipe;
    import riscv_imm_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [63:0] pc;

    // A: XLEN=32, STAGES=1    B: XLEN=64, STAGES=2
    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_imm, a_tgt;
    imm_type_t   a_type;
    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_imm, b_tgt;
    imm_type_t   b_type;

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(32), .STAGES(1)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(a_in_ready),
        .inst(inst), .pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .imm_out(a_imm), .imm_type(a_type), .target(a_tgt), .illegal(a_ill)
    );

    immgen_pipe #(.XLEN(64), .STAGES(2)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(b_in_ready),
        .inst(inst), .pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .imm_out(b_imm), .imm_type(b_type), .target(b_tgt), .illegal(b_ill)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        imm_type_t   typ;
        logic        ill;
    } res_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        imm_type_t   typ;
        logic        ill;
    } vec_t;

    int   nvec = 0;
    int   nerr = 0;
    res_t qa[$];
    res_t qb[$];
    logic a_hold = 1'b0, b_hold = 1'b0;
    res_t a_saved, b_saved;
    int   b_pops = 0;

    // ---------------- reference model ----------------
    function automatic longint sx(input longint x, input int n);
        longint f;
        f = x & ((64'sd1 <<< n) - 1);
        if (f >= (64'sd1 <<< (n - 1))) f = f - (64'sd1 <<< n);
        return f;
    endfunction

    function automatic res_t model(input logic [31:0] ins, input logic [63:0] pcv, input int xlen);
        res_t        r;
        longint      u, v;
        logic [63:0] vv, mask;
        logic [6:0]  opc;
        logic [2:0]  f3;
        u = longint'({32'b0, ins});
        opc = ins[6:0];
        f3 = ins[14:12];
        v = 0;
        r.typ = IMM_NONE;
        r.ill = 1'b0;
        case (opc)
            7'b0110011: v = 0;
            7'b0000011, 7'b1100111: begin r.typ = IMM_I; v = sx(u >> 20, 12); end
            7'b0010011:
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    r.typ = IMM_SHAMT;
                    v = (u >> 20) % ((xlen == 64) ? 64 : 32);
                end else begin
                    r.typ = IMM_I;
                    v = sx(u >> 20, 12);
                end
            7'b0100011: begin r.typ = IMM_S; v = sx(((u >> 25) << 5) + ((u >> 7) % 32), 12); end
            7'b1100011: begin
                r.typ = IMM_B;
                v = sx(((u >> 31) << 12) + (((u >> 7) % 2) << 11)
                       + (((u >> 25) % 64) << 5) + (((u >> 8) % 16) << 1), 13);
            end
            7'b0110111, 7'b0010111: begin r.typ = IMM_U; v = sx(u >> 12, 20) * 4096; end
            7'b1101111: begin
                r.typ = IMM_J;
                v = sx(((u >> 31) << 20) + (((u >> 12) % 256) << 12)
                       + (((u >> 20) % 2) << 11) + (((u >> 21) % 1024) << 1), 21);
            end
            default: r.ill = 1'b1;
        endcase
        mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        vv    = v;
        r.imm = vv & mask;
        r.tgt = (pcv + vv) & mask;
        return r;
    endfunction

    // ---------------- encoders for table entries ----------------
    function automatic logic [31:0] enc_b(input int imm);
        logic [12:0] f;
        f = imm[12:0];
        return {f[12], f[10:5], 5'd2, 5'd1, 3'b000, f[4:1], f[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [20:0] f;
        f = imm[20:0];
        return {f[20], f[10:1], f[11], f[19:12], 5'd1, 7'b1101111};
    endfunction

    // ---------------- checking helpers ----------------
    function automatic res_t a_res();
        return '{imm: {32'b0, a_imm}, tgt: {32'b0, a_tgt}, typ: a_type, ill: a_ill};
    endfunction

    function automatic res_t b_res();
        return '{imm: b_imm, tgt: b_tgt, typ: b_type, ill: b_ill};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_res(input string nm, input res_t got, input res_t exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got imm=%h tgt=%h type=%0d ill=%b, expected imm=%h tgt=%h type=%0d ill=%b",
                     nm, got.imm, got.tgt, got.typ, got.ill, exp.imm, exp.tgt, exp.typ, exp.ill);
        end
    endtask

    task automatic fail_now(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: output with no matching accepted input, expected none", nm);
    endtask

    // One clock: inputs already driven at the negedge; observe the
    // handshakes that the coming posedge will perform, then realign.
    task automatic step();
        res_t e;
        #1;
        if (a_hold) chk_res("a_stall_stable", a_res(), a_saved);
        a_hold = 1'b0;
        if (a_out_valid) begin
            if (out_ready) begin
                if (qa.size() == 0) fail_now("a_spurious");
                else begin e = qa.pop_front(); chk_res("a_stream", a_res(), e); end
            end else begin
                a_hold = 1'b1; a_saved = a_res();
            end
        end
        if (b_hold) chk_res("b_stall_stable", b_res(), b_saved);
        b_hold = 1'b0;
        if (b_out_valid) begin
            if (out_ready) begin
                b_pops++;
                if (qb.size() == 0) fail_now("b_spurious");
                else begin e = qb.pop_front(); chk_res("b_stream", b_res(), e); end
            end else begin
                b_hold = 1'b1; b_saved = b_res();
            end
        end
        if (in_valid && a_in_ready) qa.push_back(model(inst, pc, 32));
        if (in_valid && b_in_ready) qb.push_back(model(inst, pc, 64));
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("a_drained", 64'(qa.size()), 0);
        chk("b_drained", 64'(qb.size()), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        res_t ea, eb;
        ea = '{imm: {32'b0, v.imm32}, tgt: {32'b0, v.tgt32}, typ: v.typ, ill: v.ill};
        eb = '{imm: v.imm64, tgt: v.tgt64, typ: v.typ, ill: v.ill};
        inst = v.inst; pc = v.pc; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk($sformatf("tbl%0d_a_lat", idx), 64'(a_out_valid), 1);
        chk($sformatf("tbl%0d_b_early", idx), 64'(b_out_valid), 0);
        chk_res($sformatf("tbl%0d_a", idx), a_res(), ea);
        step();
        chk($sformatf("tbl%0d_b_lat", idx), 64'(b_out_valid), 1);
        chk_res($sformatf("tbl%0d_b", idx), b_res(), eb);
        step();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [10];
        logic [31:0] w;
        int          k;
        ops = '{7'b0110011, 7'b0000011, 7'b1100111, 7'b0010011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = ops[k];
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl [16];
        int   sent, budget, pops0;

        tbl[0]  = '{{12'd1241, 13'b0, 7'b0000011}, 64'h0, 32'd1241, 32'd1241, 64'd1241, 64'd1241, IMM_I, 1'b0};
        tbl[1]  = '{{12'hFFF, 13'b0, 7'b0000011}, 64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 1'b0};
        tbl[2]  = '{{7'b0, 5'd31, 5'd1, 3'b001, 5'd1, 7'b0010011}, 64'h10, 32'd31, 32'h2F, 64'd31, 64'h2F, IMM_SHAMT, 1'b0};
        tbl[3]  = '{{7'b0100000, 5'd3, 5'd1, 3'b101, 5'd1, 7'b0010011}, 64'h0, 32'd3, 32'd3, 64'd3, 64'd3, IMM_SHAMT, 1'b0};
        tbl[4]  = '{{6'b010000, 6'd40, 5'd1, 3'b101, 5'd1, 7'b0010011}, 64'h0, 32'd8, 32'd8, 64'd40, 64'd40, IMM_SHAMT, 1'b0};
        tbl[5]  = '{enc_b(2358), 64'h100, 32'd2358, 32'hA36, 64'd2358, 64'hA36, IMM_B, 1'b0};
        tbl[6]  = '{enc_j(831444), 64'h1000, 32'd831444, 32'hCBFD4, 64'd831444, 64'hCBFD4, IMM_J, 1'b0};
        tbl[7]  = '{{20'h80000, 5'd1, 7'b0110111}, 64'h40, 32'h8000_0000, 32'h8000_0040,
                    64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0040, IMM_U, 1'b0};
        tbl[8]  = '{{20'h12345, 5'd1, 7'b0010111}, 64'h1000, 32'h1234_5000, 32'h1234_6000,
                    64'h1234_5000, 64'h1234_6000, IMM_U, 1'b0};
        tbl[9]  = '{{7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 64'h44, 32'h0, 32'h44, 64'h0, 64'h44, IMM_NONE, 1'b0};
        tbl[10] = '{{25'h0ABCDE, 7'b1111111}, 64'h8, 32'h0, 32'h8, 64'h0, 64'h8, IMM_NONE, 1'b1};
        tbl[11] = '{{7'b1111111, 5'd2, 5'd1, 3'b010, 5'b11100, 7'b0100011}, 64'h100, 32'hFFFF_FFFC, 32'hFC,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'hFC, IMM_S, 1'b0};
        tbl[12] = '{enc_b(-8), 64'h100, 32'hFFFF_FFF8, 32'hF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'hF8, IMM_B, 1'b0};
        tbl[13] = '{enc_j(-4), 64'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, IMM_J, 1'b0};
        tbl[14] = '{{12'h7FF, 5'd1, 3'b000, 5'd1, 7'b1100111}, 64'h10, 32'h7FF, 32'h80F, 64'h7FF, 64'h80F, IMM_I, 1'b0};
        tbl[15] = '{{12'hFFF, 5'd1, 3'b000, 5'd1, 7'b0010011}, 64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 1'b0};

        // Reset state
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0; pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_valid", 64'(a_out_valid), 0);
        chk("rst_b_valid", 64'(b_out_valid), 0);
        chk_res("rst_a_out", a_res(), '{imm: 64'h0, tgt: 64'h0, typ: IMM_NONE, ill: 1'b0});
        chk_res("rst_b_out", b_res(), '{imm: 64'h0, tgt: 64'h0, typ: IMM_NONE, ill: 1'b0});
        rstn = 1'b1;
        #1;
        chk("rst_a_ready", 64'(a_in_ready), 1);
        chk("rst_b_ready", 64'(b_in_ready), 1);
        @(negedge clk);

        // Table-driven single instructions with exact latency
        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);
        drain();

        // Full throughput on the two-stage instance
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; inst = rand_inst(); pc = {$urandom, $urandom};
            #1;
            chk($sformatf("tput_b_ready%0d", i), 64'(b_in_ready), 1);
            step();
            chk($sformatf("tput_b_valid%0d", i), 64'(b_out_valid), (i >= 1) ? 64'd1 : 64'd0);
        end
        drain();

        // Backpressure: 6 instructions, out_ready high one cycle in three
        sent = 0; budget = 0; pops0 = b_pops;
        while ((sent < 6 || qb.size() != 0 || b_out_valid) && budget < 80) begin
            logic acc;
            in_valid = (sent < 6);
            out_ready = (budget % 3 == 2);
            inst = {20'(sent * 37 + 5), 5'(sent), 7'b0110111};
            pc = 64'(sent) << 4;
            #1;
            acc = in_valid && b_in_ready;
            step();
            if (acc) sent++;
            budget++;
        end
        chk("bp_b_count", 64'(b_pops - pops0), 6);
        chk("bp_b_budget", 64'(budget < 80), 1);
        drain();

        // Randomized stream against the model
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            inst = rand_inst();
            pc = {$urandom, $urandom};
            step();
        end
        drain();

        // Reset with two instructions in flight
        in_valid = 1'b1; out_ready = 1'b0; inst = tbl[5].inst; pc = tbl[5].pc;
        step();
        inst = tbl[6].inst; pc = tbl[6].pc;
        step();
        #2 rstn = 1'b0;
        #1;
        chk("midrst_a_valid", 64'(a_out_valid), 0);
        chk("midrst_b_valid", 64'(b_out_valid), 0);
        chk_res("midrst_b_out", b_res(), '{imm: 64'h0, tgt: 64'h0, typ: IMM_NONE, ill: 1'b0});
        qa.delete(); qb.delete(); a_hold = 1'b0; b_hold = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("postrst_b_ready", 64'(b_in_ready), 1);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("postrst_a_valid%0d", i), 64'(a_out_valid), 0);
            chk($sformatf("postrst_b_valid%0d", i), 64'(b_out_valid), 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
